// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the latency-modelled data memory responder.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package data_mem_responder_pkg;

   // Width of one storage word and of the load/store data buses.
   localparam int WORD_W = 32;

   // Request FSM encoding. The values are kept stable for older code that compares against them.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // The captured operation and its store data. The word index is kept separately
   // because its width depends on the memory depth.
   typedef struct packed {
      logic              is_store;
      logic [WORD_W-1:0] data;
   } req_t;

   // A request is only real if at least one operation bit is set.
   function automatic logic is_mem_op(input logic rd, input logic wr);
      return rd | wr;
   endfunction

   // If both bits are set, the request is treated as a store.
   function automatic logic resolve_store(input logic rd, input logic wr);
      return wr | (rd & wr);
   endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Word-addressed storage: the write happens on the clock edge, and the read is combinational.
// Latency: a write is visible on the next cycle; a read is visible in the same cycle.
// Backpressure: none; every write enable is honoured. Contents are never reset.
module data_mem_responder_array
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH = 16384,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_idx,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_idx,
   output logic [WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] mem [DEPTH];

   // Commit a store into the array. There is no reset, so the contents survive a reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder that accepts one load or store at a time and answers after a fixed delay.
// Latency: a request accepted in cycle T is busy for T+1..T+DELAY, pulses in T+DELAY+1, and is ready again in T+DELAY+2.
// Backpressure: is_ready is high only in IDLE; requests presented at other times are ignored and must be held.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter  int MEM_DEPTH = 16384,
   parameter  int DELAY     = 4,
   localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              is_input_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       addr,
   input  logic [WORD_W-1:0] din,
   output logic              is_ready,
   output logic              is_output_valid,
   output logic              is_write_done,
   output logic [WORD_W-1:0] dout
);

   localparam int CNT_W = $clog2(DELAY + 1);

   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] cap_idx;
   req_t              cap_req;
   logic              accept;
   logic              finish;
   logic              mem_we;
   logic [WORD_W-1:0] rd_data;

   // The byte offset and the address bits above the memory size are not used;
   // the high bits simply alias back onto the array.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

   assign is_ready = (state == ST_IDLE);
   assign accept   = is_ready && is_input_valid && is_mem_op(mem_read, mem_write);
   assign finish   = (state == ST_BUSY) && (cnt == '0);

   // Reset takes priority, so a store that is still pending when reset arrives is never written.
   assign mem_we   = finish && cap_req.is_store && !reset;

   data_mem_responder_array #(
      .DEPTH (MEM_DEPTH),
      .AW    (ADDR_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (mem_we),
      .wr_idx  (cap_idx),
      .wr_data (cap_req.data),
      .rd_idx  (cap_idx),
      .rd_data (rd_data)
   );

   // Request FSM: capture the request, count down the modelled latency, then pulse the result for one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         cap_idx         <= '0;
         cap_req         <= '0;
         is_output_valid <= 1'b0;
         is_write_done   <= 1'b0;
         dout            <= '0;
      end else begin
         is_output_valid <= 1'b0;
         is_write_done   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cap_idx          <= addr[ADDR_W+1:2];
                  cap_req.data     <= din;
                  cap_req.is_store <= resolve_store(mem_read, mem_write);
                  cnt              <= CNT_W'(DELAY - 1);
                  state            <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt == '0) begin
                  state <= ST_DONE;
                  if (cap_req.is_store) begin
                     is_write_done <= 1'b1;
                  end else begin
                     is_output_valid <= 1'b1;
                     dout            <= rd_data;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Latency-modelled data memory that services the load/store requests the decode stage raises via mem_read/mem_write.
- Sits between the CPU memory stage and a word-addressed storage array.
- Accepts one request at a time over a valid/ready handshake and returns read data after a fixed, parameterised latency.
- Used by the multi-cycle and pipelined cores to exercise stall logic.

Parameters:
- MEM_DEPTH, 16384, number of 32-bit words; power of two.
- DELAY, 4, cycles spent in BUSY per request; must be >= 1.
- ADDR_W, $clog2(MEM_DEPTH), word-index width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- is_input_valid  input  1  request present this cycle.
- mem_read  input  1  request is a load.
- mem_write  input  1  request is a store.
- addr  input  32  byte address; bits [1:0] ignored.
- din  input  32  store data.
- is_ready  output  1  responder can accept a request this cycle.
- is_output_valid  output  1  one-cycle pulse: dout holds load data.
- is_write_done  output  1  one-cycle pulse: store committed.
- dout  output  32  load data.

Behaviour:
- Reset is synchronous and active-high, sampled on clk: state=IDLE, counter=0, is_output_valid=0, is_write_done=0, dout=0, captured request cleared. Memory array contents are NOT cleared.
- States:
  - IDLE: is_ready=1.
  - BUSY: is_ready=0.
  - DONE: is_ready=0.
- Accept condition: IDLE && is_input_valid && (mem_read || mem_write).
  - On acceptance, capture addr[ADDR_W+1:2], din and op, load counter=DELAY-1, go BUSY.
  - is_input_valid with neither op bit set is ignored; remain IDLE.
- Op resolution: if mem_read and mem_write are both 1, the request executes as a store only. No is_output_valid.
- BUSY:
  - Counter decrements each cycle.
  - When counter==0, transition to DONE.
  - On that same edge: a store writes the array; a load registers array[index] into dout.
- DONE lasts exactly one cycle.
  - is_output_valid=1 for loads; is_write_done=1 for stores; never both.
  - Next state IDLE.
- Timing for a request accepted in cycle T:
  - BUSY occupies T+1..T+DELAY.
  - DONE (pulse) in T+DELAY+1.
  - is_ready=1 again in T+DELAY+2.
- is_input_valid, addr, din and op bits are ignored outside IDLE. Requesters must hold the request until accepted.
- dout holds its last load value until the next load completes or reset. Stores do not change dout.
- Address wrap: index = addr[ADDR_W+1:2]; higher address bits alias modulo MEM_DEPTH.
- Reset mid-operation (BUSY or DONE): return to IDLE next cycle, pending store discarded (array unchanged), no pulses.
- Reset has priority over every other event in the same cycle.

Decomposition:
- Shared header (alongside opcodes.v): state encoding macros for IDLE/BUSY/DONE and the word width (32).
- One sub-module, data_mem_array: synchronous-write, combinational-read word array (MEM_DEPTH x 32).
- The top holds the FSM, counter and capture registers.

Test Plan:
1. DELAY=4, store 0xDEADBEEF to 0x100 accepted at T:
   - is_write_done only at T+5; is_ready back at T+6.
   - Then a load of 0x100 gives dout=0xDEADBEEF with is_output_valid exactly 5 cycles after its acceptance.
2. Busy rejection: load of 0x100 accepted at T; store of 0x0BADF00D to 0x100 presented at T+2 with is_input_valid=1:
   - is_ready=0 and the store is dropped.
   - The first load returns the old value; a later load still returns 0xDEADBEEF.
3. Both op bits set: mem_read=mem_write=1, din=0x12345678, addr=0x20:
   - is_write_done pulses, is_output_valid stays 0, dout unchanged.
   - A subsequent load of 0x20 returns 0x12345678.
4. Reset mid-store: 0x200 holds 0x11111111; store 0x22222222 to 0x200; assert reset at T+2:
   - Outputs go to reset values and is_ready=1 the cycle after reset.
   - A load of 0x200 returns 0x11111111.
5. Aliasing, MEM_DEPTH=16: store 0xCAFEF00D to 0x40; load of 0x0 returns 0xCAFEF00D.
6. No-op and misaligned requests:
   - is_input_valid=1 with mem_read=mem_write=0 for 3 cycles: state stays IDLE, is_ready stays 1, no pulses.
   - A load of 0x103 returns the same word as 0x100.
